// File: rtl/rv_sram_arb_ctrl.sv
// Two-port arbiter and timing sequencer for a 16-bit asynchronous SRAM.
// Each 32-bit request becomes up to two halfword SRAM cycles (LO, then HI).
// A halfword cycle is SETUP (1) + ACC (WAIT_CYC) + HOLD (1, writes only).
// All outputs come from registers. The registered controls are driven from the
// next state, so each pin value appears in the same cycle as the FSM state that
// produces it.
module rv_sram_arb_ctrl #(
    parameter int WAIT_CYC = 2
) (
    input  logic             clk,
    input  logic             arstn_i,
    input  logic [1:0]       req_i,
    input  logic [1:0]       we_i,
    input  logic [1:0][31:0] addr_i,
    input  logic [1:0][3:0]  be_i,
    input  logic [1:0][31:0] wdata_i,
    output logic [1:0]       gnt_o,
    output logic [1:0]       rvalid_o,
    output logic [31:0]      rdata_o,
    output logic [19:0]      sram_addr,
    input  logic [15:0]      sram_data_i,
    output logic [15:0]      sram_data_o,
    output logic             sram_ce_n,
    output logic             sram_oe_n,
    output logic             sram_we_n,
    output logic             sram_ub_n,
    output logic             sram_lb_n
);

    typedef enum logic [2:0] {IDLE, SETUP, ACC, HOLD, DONE} state_t;

    localparam logic [3:0] ACC_LAST = 4'(WAIT_CYC - 1);

    state_t      state_q, state_d;
    logic        pend_q, pend_d;      // grant issued, first phase not yet started
    logic        port_q, port_d;
    logic        we_q, we_d;
    logic [18:0] waddr_q, waddr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        half_q, half_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rr_last_q, rr_last_d;
    logic [15:0] rlo_q, rlo_d;        // low halfword held until the read completes

    logic        g;
    logic        active;
    logic [1:0]  gnt_d, rvalid_d;
    logic [31:0] rdata_d;
    logic [19:0] addr_d;
    logic [15:0] dout_d;
    logic        ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d;

    // FSM state and captured request context
    always_ff @(posedge clk or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q   <= IDLE;
            pend_q    <= 1'b0;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            half_q    <= 1'b0;
            cnt_q     <= '0;
            rr_last_q <= 1'b1;
            rlo_q     <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            port_q    <= port_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            half_q    <= half_d;
            cnt_q     <= cnt_d;
            rr_last_q <= rr_last_d;
            rlo_q     <= rlo_d;
        end
    end

    // Next state, arbitration and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        port_d    = port_q;
        we_d      = we_q;
        waddr_d   = waddr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        half_d    = half_q;
        cnt_d     = cnt_q;
        rr_last_d = rr_last_q;
        rlo_d     = rlo_q;
        rdata_d   = rdata_o;
        gnt_d     = '0;
        g         = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (!we_q || be_q[1:0] != 2'b00) begin
                        state_d = SETUP;
                        half_d  = 1'b0;
                    end else if (be_q[3:2] != 2'b00) begin
                        state_d = SETUP;
                        half_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end else if (req_i != 2'b00) begin
                    g         = (req_i == 2'b11) ? ~rr_last_q : req_i[1];
                    gnt_d[g]  = 1'b1;
                    pend_d    = 1'b1;
                    port_d    = g;
                    rr_last_d = g;
                    we_d      = we_i[g];
                    waddr_d   = addr_i[g][20:2];
                    be_d      = be_i[g];
                    wdata_d   = wdata_i[g];
                end
            end
            SETUP: begin
                state_d = ACC;
                cnt_d   = '0;
            end
            ACC: begin
                if (cnt_q == ACC_LAST) begin
                    if (we_q) begin
                        state_d = HOLD;
                    end else if (!half_q) begin
                        rlo_d   = sram_data_i;
                        state_d = SETUP;
                        half_d  = 1'b1;
                    end else begin
                        rdata_d = {sram_data_i, rlo_q};
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HOLD: begin
                if (!half_q && be_q[3:2] != 2'b00) begin
                    state_d = SETUP;
                    half_d  = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        active = (state_d == SETUP) || (state_d == ACC) || (state_d == HOLD);
        ce_n_d = !active;
        oe_n_d = !(state_d == ACC && !we_d);
        we_n_d = !(state_d == ACC && we_d);
        addr_d = sram_addr;
        dout_d = sram_data_o;
        ub_n_d = sram_ub_n;
        lb_n_d = sram_lb_n;
        if (!active) begin
            ub_n_d = 1'b1;
            lb_n_d = 1'b1;
        end else if (state_d == SETUP) begin
            // SETUP is only ever entered, never repeated: load the phase
            addr_d = {waddr_d, half_d};
            if (we_d) begin
                {ub_n_d, lb_n_d} = half_d ? ~be_d[3:2] : ~be_d[1:0];
                dout_d           = half_d ? wdata_d[31:16] : wdata_d[15:0];
            end else begin
                {ub_n_d, lb_n_d} = 2'b00;
            end
        end
        rvalid_d         = '0;
        rvalid_d[port_d] = (state_d == DONE);
    end

    // Output registers
    always_ff @(posedge clk or negedge arstn_i) begin
        if (!arstn_i) begin
            gnt_o       <= '0;
            rvalid_o    <= '0;
            rdata_o     <= '0;
            sram_addr   <= '0;
            sram_data_o <= '0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
        end else begin
            gnt_o       <= gnt_d;
            rvalid_o    <= rvalid_d;
            rdata_o     <= rdata_d;
            sram_addr   <= addr_d;
            sram_data_o <= dout_d;
            sram_ce_n   <= ce_n_d;
            sram_oe_n   <= oe_n_d;
            sram_we_n   <= we_n_d;
            sram_ub_n   <= ub_n_d;
            sram_lb_n   <= lb_n_d;
        end
    end

endmodule
